// File: rtl/mips_trace_buffer.sv
// WB-stage retirement trace buffer with PC trigger and valid/ready drain.
// Optional cycle stamp per entry: define MIPS_TRACE_CYCLE_STAMP_EN.
module mips_trace_buffer #(
   parameter int DEPTH        = 16,
   parameter int POST_TRIGGER = 8,
   parameter int CYCLE_WIDTH  = 16,
   localparam int AW          = $clog2(DEPTH),
   localparam int CW          = AW + 1,
`ifdef MIPS_TRACE_CYCLE_STAMP_EN
   localparam bit STAMP_EN    = 1'b1,
`else
   localparam bit STAMP_EN    = 1'b0,
`endif
   localparam int ENTRY_W     = 102 + (STAMP_EN ? CYCLE_WIDTH : 0)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               wb_valid,
   input  logic [31:0]        wb_pc,
   input  logic [31:0]        wb_instr,
   input  logic               wb_reg_write,
   input  logic [4:0]         wb_write_register,
   input  logic [31:0]        wb_write_data,
   input  logic               trig_en,
   input  logic [31:0]        trig_pc,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic [ENTRY_W-1:0] rd_entry,
   output logic [1:0]         state,
   output logic [CW-1:0]      count,
   output logic               overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [AW-1:0] wp_q, wp_d;
   logic [AW-1:0] rp_q, rp_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] post_cnt_q, post_cnt_d;
   logic          overflow_q, overflow_d;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] wr_entry;

   logic capture;
   logic trig_hit;
   logic full;
   logic arm;
   logic xfer;

   assign capture  = wb_valid &&
                     (state_q == S_ARMED || state_q == S_POST);
   assign trig_hit = trig_en && wb_valid &&
                     (wb_pc == trig_pc) && (state_q == S_ARMED);
   assign full     = (count_q == CW'(DEPTH));
   assign arm      = (state_q == S_IDLE) && enable;
   assign xfer     = rd_valid && rd_ready;

`ifdef MIPS_TRACE_CYCLE_STAMP_EN
   logic [CYCLE_WIDTH-1:0] cyc_q, cyc_d;

   assign cyc_d = cyc_q + CYCLE_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (reset) cyc_q <= '0;
      else       cyc_q <= cyc_d;
   end

   assign wr_entry = {cyc_q, wb_pc, wb_instr, wb_reg_write,
                      wb_write_register, wb_write_data};
`else
   assign wr_entry = {wb_pc, wb_instr, wb_reg_write,
                      wb_write_register, wb_write_data};
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; a trigger outranks a same-cycle abort
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (trig_hit)
               state_d = (POST_TRIGGER == 0) ? S_DONE : S_POST;
            else if (!enable)
               state_d = S_DONE;
         end
         S_POST: begin
            if (!enable ||
                (capture && post_cnt_q == CW'(1)))
               state_d = S_DONE;
         end
         S_DONE: begin
            if (count_q == '0 && !enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Pointer / occupancy datapath
   always_comb begin
      wp_d       = wp_q;
      rp_d       = rp_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      post_cnt_d = post_cnt_q;
      if (arm) begin
         wp_d       = '0;
         rp_d       = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else if (capture) begin
         wp_d = wp_q + AW'(1);
         if (full) begin
            rp_d       = rp_q + AW'(1);
            overflow_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (xfer) begin
         rp_d    = rp_q + AW'(1);
         count_d = count_q - CW'(1);
      end
      if (trig_hit)
         post_cnt_d = CW'(POST_TRIGGER);
      else if (state_q == S_POST && capture)
         post_cnt_d = post_cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         post_cnt_q <= '0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         post_cnt_q <= post_cnt_d;
      end
   end

   // Storage is not reset; an entry offered during reset is dropped
   always_ff @(posedge clk) begin
      if (!reset && capture) mem_q[wp_q] <= wr_entry;
   end

   // Outputs
   always_comb begin
      rd_valid = (state_q == S_DONE) && (count_q != '0);
      rd_entry = mem_q[rp_q];
      state    = state_q;
      count    = count_q;
      overflow = overflow_q;
   end

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Synthesizable retirement-trace capture for the 5-stage MIPS pipeline. It sits beside the `mips` top level and snoops the WB stage. Each retiring instruction (PC, instruction word, register write-back) is recorded into a parametrised circular buffer. On a PC-match trigger it freezes a pre- and post-trigger window, which is then drained through a valid/ready read port. Benches and on-chip debug use it in place of cycle-by-cycle `$display` monitoring.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 2
- `POST_TRIGGER`, 8, entries captured after the trigger entry; must be < `DEPTH`
- `CYCLE_WIDTH`, 16, width of the cycle stamp; used only with `MIPS_TRACE_CYCLE_STAMP_EN`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  arm/keep capturing; low aborts capture
- `wb_valid`  in  1  an instruction retires in WB this cycle
- `wb_pc`  in  32  PC of the retiring instruction
- `wb_instr`  in  32  instruction word
- `wb_reg_write`  in  1  RegWrite of the retiring instruction
- `wb_write_register`  in  5  destination register
- `wb_write_data`  in  32  write-back data
- `trig_en`  in  1  enables PC-match trigger
- `trig_pc`  in  32  trigger PC
- `rd_valid`  out  1  entry available on `rd_entry`
- `rd_ready`  in  1  consumer accepts entry
- `rd_entry`  out  ENTRY_W  {[stamp], pc, instr, reg_write, write_register, write_data}; ENTRY_W = 102, or 102+`CYCLE_WIDTH` with the macro
- `state`  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `count`  out  $clog2(DEPTH)+1  valid entries held
- `overflow`  out  1  sticky: oldest entry was overwritten

## Operation
- Storage: `DEPTH`-entry array, write pointer `wp`, read pointer `rp`, `count`. Pointers wrap modulo `DEPTH`.
- Capture event: `wb_valid` high in ARMED or POST. Writes the entry at `wp`, then `wp++`.
  - If not full: `count++`.
  - If full: `rp++`, `count` is unchanged, `overflow` is set to 1.
- Trigger: `trig_en && wb_valid && wb_pc == trig_pc` while in ARMED. The triggering entry is itself captured.
- FSM:
  - IDLE: no capture. When `enable` = 1, go to ARMED. On entry to ARMED from IDLE, `count`, `wp`, `rp` and `overflow` are cleared.
  - ARMED: circular capture.
    - On trigger with `POST_TRIGGER` = 0, go to DONE.
    - On trigger with `POST_TRIGGER` > 0, go to POST and load `post_cnt` = `POST_TRIGGER`.
    - If `enable` = 0 and there is no trigger this cycle, go to DONE (frozen).
  - POST: each capture event decrements `post_cnt`.
    - The capture that brings `post_cnt` to 0 moves the FSM to DONE.
    - `enable` = 0 goes to DONE; a capture in that same cycle is still written.
  - DONE: no capture; `wb_*` are ignored. Drain via the read port. When `count` = 0 and `enable` = 0, go to IDLE. When `count` = 0 and `enable` = 1, stay in DONE; a new arm requires `enable` to be low for at least one cycle.
- Read port:
  - `rd_valid` = (state == DONE) && (count != 0).
  - `rd_entry` = mem[`rp`], combinational, oldest first.
  - A transfer (`rd_valid && rd_ready`) does `rp++` and `count--`.
  - `rd_valid` is never asserted outside DONE.
- The trigger comparator is ignored in POST and DONE, so re-matches have no effect.

## Timing
- A capture is written at the rising edge where `wb_valid` = 1. `count` reflects it from the next cycle.
- The state change on a trigger takes effect at that same edge.
- First `rd_valid` appears the cycle after DONE is entered. Drain rate is one entry per cycle.
- Reset values: `state` = IDLE, `count` = 0, `overflow` = 0, `rd_valid` = 0, `wp` = `rp` = 0, cycle stamp = 0.
  - `rd_entry` is don't-care while `rd_valid` = 0.
  - Array contents are not reset.
- Reset asserted mid-capture or mid-drain: all state returns to the reset values at that edge. The entry offered in that cycle is discarded.

## Configuration
- `MIPS_TRACE_CYCLE_STAMP_EN` defined:
  - Adds a free-running `CYCLE_WIDTH`-bit counter, reset to 0, incrementing every cycle and wrapping.
  - Its value at the capture edge is prepended as the MSBs of each entry.
- Not defined: no counter, and ENTRY_W = 102.

## Test plan
- Reset then `enable` = 1, 5 retires at PC 0x0,0x4,…,0x10, no trigger, then `enable` = 0 -> DONE, `count` = 5, `overflow` = 0. Drain with `rd_ready` = 1 returns PCs 0x0..0x10 in order; then `rd_valid` = 0, and IDLE once `enable` is low.
- `DEPTH` = 16, 20 retires PC 0x0..0x4C, abort -> `count` = 16, `overflow` = 1, first entry PC 0x10, last 0x4C.
- `trig_pc` = 0x20, `POST_TRIGGER` = 8, 30 sequential retires -> DONE after the PC 0x40 capture. `count` = 16, entries PC 0x04..0x40; further retires are ignored.
- `POST_TRIGGER` = 0, trigger at PC 0x8 -> DONE at the same edge; last entry PC 0x8.
- Drain with `rd_ready` toggling 1,0,1,0 -> one entry per high cycle, no duplicates or skips. `reset` pulse mid-drain -> `count` = 0, `rd_valid` = 0, IDLE next cycle.
- With `MIPS_TRACE_CYCLE_STAMP_EN`: retire at cycles 3 and 7 after reset -> stamps 3 and 7.
